pipe_hold_ctrl: RTL and testbench

- Central pipeline hazard controller for the 5-stage RV64 core.
- Gathers stall and jump requests from the ID, EX and memory stages.
- Sequences the hold_flag codes consumed by the IF_ID and ID_EX pipeline registers, plus the PC hold, jump flag and jump address for the PC register.
- Latches a jump that arrives during a multi-cycle stall and issues it when the stall releases. Supports multi-cycle flush bubbles.

---
 rtl/pipe_hold_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hazard controller for the 5-stage RV64 core: stall/jump/flush sequencing.
// Optional perf counters are enabled by defining PIPE_HOLD_CTRL_PERF_EN.
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int AW           = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_req_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          stall_mem_i,
    input  logic          stall_div_i,
    input  logic          stall_ld_use_i,
    output logic          pc_hold_o,
    output logic          jump_flag_o,
    output logic [AW-1:0] jump_addr_o,
    output logic [1:0]    hold_flag_if_id_o,
    output logic [1:0]    hold_flag_id_ex_o,
`ifdef PIPE_HOLD_CTRL_PERF_EN
    output logic [31:0]   perf_stall_cnt_o,
    output logic [31:0]   perf_flush_cnt_o,
`endif
    output logic          busy_o
);

    localparam logic [1:0] HOLD_PASS  = 2'b00;
    localparam logic [1:0] HOLD_FLUSH = 2'b01;
    localparam logic [1:0] HOLD_STALL = 2'b10;
    localparam int         CW         = 3;
    localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    typedef struct packed {
        logic          pc_hold;
        logic          jump_flag;
        logic [AW-1:0] jump_addr;
        logic [1:0]    if_id;
        logic [1:0]    id_ex;
    } hold_rsp_t;

    state_t          state, nxt_state;
    logic            pend_vld, nxt_pend_vld;
    logic [AW-1:0]   pend_addr, nxt_pend_addr;
    logic [CW-1:0]   flush_cnt, nxt_flush_cnt;
    logic            hard_stall;
    hold_rsp_t       rsp;

    assign hard_stall = stall_mem_i | stall_div_i;

    always_comb begin
        rsp           = '0;
        nxt_state     = state;
        nxt_pend_vld  = pend_vld;
        nxt_pend_addr = pend_addr;
        nxt_flush_cnt = flush_cnt;

        if (state == FLUSH) begin
            // mem/div stall freezes the flush countdown; EX holds a bubble so jumps are dropped
            if (hard_stall) begin
                rsp.pc_hold = 1'b1;
                rsp.if_id   = HOLD_STALL;
                rsp.id_ex   = HOLD_STALL;
            end else begin
                rsp.if_id = HOLD_FLUSH;
                rsp.id_ex = HOLD_PASS;
                if (flush_cnt <= CW'(1)) begin
                    nxt_flush_cnt = '0;
                    nxt_state     = RUN;
                end else begin
                    nxt_flush_cnt = flush_cnt - CW'(1);
                end
            end
        end else if (hard_stall) begin
            rsp.pc_hold = 1'b1;
            rsp.if_id   = HOLD_STALL;
            rsp.id_ex   = HOLD_STALL;
            nxt_state   = STALL;
            if (jump_req_i && !pend_vld) begin
                nxt_pend_vld  = 1'b1;
                nxt_pend_addr = jump_addr_i;
            end
        end else if (state == STALL && pend_vld) begin
            rsp.jump_flag = 1'b1;
            rsp.jump_addr = pend_addr;
            rsp.if_id     = HOLD_FLUSH;
            rsp.id_ex     = HOLD_FLUSH;
            nxt_pend_vld  = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                nxt_state     = FLUSH;
                nxt_flush_cnt = FLUSH_INIT;
            end else begin
                nxt_state = RUN;
            end
        end else begin
            // RUN, or a STALL release with nothing pending (handled as a RUN cycle)
            nxt_state = RUN;
            if (jump_req_i) begin
                rsp.jump_flag = 1'b1;
                rsp.jump_addr = jump_addr_i;
                rsp.if_id     = HOLD_FLUSH;
                rsp.id_ex     = HOLD_FLUSH;
                if (FLUSH_CYCLES > 1) begin
                    nxt_state     = FLUSH;
                    nxt_flush_cnt = FLUSH_INIT;
                end
            end else if (stall_ld_use_i) begin
                rsp.pc_hold = 1'b1;
                rsp.if_id   = HOLD_STALL;
                rsp.id_ex   = HOLD_FLUSH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= nxt_state;
            pend_vld  <= nxt_pend_vld;
            pend_addr <= nxt_pend_addr;
            flush_cnt <= nxt_flush_cnt;
        end
    end

    // Outputs are forced quiet while reset is asserted, even with live requests
    assign pc_hold_o         = rsp.pc_hold & ~rst;
    assign jump_flag_o       = rsp.jump_flag & ~rst;
    assign jump_addr_o       = rst ? '0 : rsp.jump_addr;
    assign hold_flag_if_id_o = rst ? HOLD_PASS : rsp.if_id;
    assign hold_flag_id_ex_o = rst ? HOLD_PASS : rsp.id_ex;
    assign busy_o            = ~rst & (state != RUN);

`ifdef PIPE_HOLD_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (pc_hold_o && perf_stall_cnt_o != 32'hFFFF_FFFF)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (jump_flag_o && perf_flush_cnt_o != 32'hFFFF_FFFF)
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: FLUSH_CYCLES=1 and =3 instances share stimulus,
// checked every cycle against a request-level model plus literal expectations.
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_req = 1'b0;
    logic [63:0] jump_addr = '0;
    logic        stall_mem = 1'b0, stall_div = 1'b0, stall_ld = 1'b0;

    logic        a_ph, a_jf, a_busy, b_ph, b_jf, b_busy;
    logic [63:0] a_ja, b_ja;
    logic [1:0]  a_ii, a_ie, b_ii, b_ie;
`ifdef PIPE_HOLD_CTRL_PERF_EN
    logic [31:0] a_ps, a_pf, b_ps, b_pf;
`endif
    logic [70:0] a_vec, b_vec;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hold_ctrl #(.FLUSH_CYCLES(1), .AW(64)) dut_a (
        .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
        .stall_mem_i(stall_mem), .stall_div_i(stall_div), .stall_ld_use_i(stall_ld),
        .pc_hold_o(a_ph), .jump_flag_o(a_jf), .jump_addr_o(a_ja),
        .hold_flag_if_id_o(a_ii), .hold_flag_id_ex_o(a_ie),
`ifdef PIPE_HOLD_CTRL_PERF_EN
        .perf_stall_cnt_o(a_ps), .perf_flush_cnt_o(a_pf),
`endif
        .busy_o(a_busy));

    pipe_hold_ctrl #(.FLUSH_CYCLES(3), .AW(64)) dut_b (
        .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
        .stall_mem_i(stall_mem), .stall_div_i(stall_div), .stall_ld_use_i(stall_ld),
        .pc_hold_o(b_ph), .jump_flag_o(b_jf), .jump_addr_o(b_ja),
        .hold_flag_if_id_o(b_ii), .hold_flag_id_ex_o(b_ie),
`ifdef PIPE_HOLD_CTRL_PERF_EN
        .perf_stall_cnt_o(b_ps), .perf_flush_cnt_o(b_pf),
`endif
        .busy_o(b_busy));

    assign a_vec = {a_ph, a_jf, a_ja, a_ii, a_ie, a_busy};
    assign b_vec = {b_ph, b_jf, b_ja, b_ii, b_ie, b_busy};

    function automatic logic [70:0] mk(logic ph, logic jf, logic [63:0] ja,
                                       logic [1:0] ii, logic [1:0] ie, logic bz);
        return {ph, jf, ja, ii, ie, bz};
    endfunction

    task automatic chk(string name, logic [70:0] act, logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: pending jump slot, remaining flush bubbles, and whether a stall is in progress
    bit          m_stalled [2];
    bit          m_pv      [2];
    logic [63:0] m_pa      [2];
    int          m_left    [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [70:0] e;
            int fc;
            bit hs, bz;
            fc = (k == 0) ? 1 : 3;
            hs = stall_mem | stall_div;
            bz = m_stalled[k] || (m_left[k] > 0);
            e  = '0;
            if (rst) begin
                m_stalled[k] = 0; m_pv[k] = 0; m_pa[k] = '0; m_left[k] = 0;
            end else if (m_left[k] > 0) begin
                if (hs) e = mk(1'b1, 1'b0, '0, 2'b10, 2'b10, 1'b1);
                else begin
                    e = mk(1'b0, 1'b0, '0, 2'b01, 2'b00, 1'b1);
                    m_left[k]--;
                end
            end else if (hs) begin
                e = mk(1'b1, 1'b0, '0, 2'b10, 2'b10, bz);
                if (jump_req && !m_pv[k]) begin m_pv[k] = 1; m_pa[k] = jump_addr; end
                m_stalled[k] = 1;
            end else if (m_pv[k]) begin
                e = mk(1'b0, 1'b1, m_pa[k], 2'b01, 2'b01, bz);
                m_pv[k] = 0; m_stalled[k] = 0; m_left[k] = fc - 1;
            end else begin
                m_stalled[k] = 0;
                if (jump_req) begin
                    e = mk(1'b0, 1'b1, jump_addr, 2'b01, 2'b01, bz);
                    m_left[k] = fc - 1;
                end else if (stall_ld) begin
                    e = mk(1'b1, 1'b0, '0, 2'b10, 2'b01, bz);
                end else begin
                    e = mk(1'b0, 1'b0, '0, 2'b00, 2'b00, bz);
                end
            end
            if (k == 0) chk("model_fc1", a_vec, e);
            else        chk("model_fc3", b_vec, e);
        end
    end

    task automatic step(logic j, logic [63:0] a, logic m, logic d, logic l);
        @(posedge clk); #1;
        jump_req = j; jump_addr = a; stall_mem = m; stall_div = d; stall_ld = l;
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        chk("reset_a", a_vec, '0);
        chk("reset_b", b_vec, '0);
        jump_req = 1'b1; jump_addr = 64'hDEAD; stall_div = 1'b1;
        #1;
        chk("reset_gated_a", a_vec, '0);
        jump_req = 1'b0; jump_addr = '0; stall_div = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        idle();

        // Jump in RUN
        step(1'b1, 64'h8000_0040, 1'b0, 1'b0, 1'b0);
        chk("jump_a", a_vec, mk(1'b0, 1'b1, 64'h8000_0040, 2'b01, 2'b01, 1'b0));
        chk("jump_b", b_vec, mk(1'b0, 1'b1, 64'h8000_0040, 2'b01, 2'b01, 1'b0));
        idle();
        chk("jump_after_a", a_vec, '0);
        chk("flush1_b", b_vec, mk(1'b0, 1'b0, '0, 2'b01, 2'b00, 1'b1));
        idle();
        chk("flush2_b", b_vec, mk(1'b0, 1'b0, '0, 2'b01, 2'b00, 1'b1));
        idle();
        chk("flush_done_b", b_vec, '0);

        // Load-use bubble
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ldu_a", a_vec, mk(1'b1, 1'b0, '0, 2'b10, 2'b01, 1'b0));
        idle();
        chk("ldu_after_a", a_vec, '0);

        // Jump latched during a divider stall
        for (int i = 0; i < 5; i++) begin
            step(i == 2, (i == 2) ? 64'h100 : 64'h0, 1'b0, 1'b1, 1'b0);
            chk("div_stall_a", a_vec, mk(1'b1, 1'b0, '0, 2'b10, 2'b10, i > 0));
        end
        idle();
        chk("div_release_a", a_vec, mk(1'b0, 1'b1, 64'h100, 2'b01, 2'b01, 1'b1));
        chk("div_release_b", b_vec, mk(1'b0, 1'b1, 64'h100, 2'b01, 2'b01, 1'b1));
        idle(); idle(); idle();

        // Mem stall inside a flush window
        step(1'b1, 64'h2000, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_stall1_b", b_vec, mk(1'b1, 1'b0, '0, 2'b10, 2'b10, 1'b1));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_stall2_b", b_vec, mk(1'b1, 1'b0, '0, 2'b10, 2'b10, 1'b1));
        idle();
        chk("flush_resume1_b", b_vec, mk(1'b0, 1'b0, '0, 2'b01, 2'b00, 1'b1));
        chk("stall_release_a", a_vec, mk(1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b1));
        idle();
        chk("flush_resume2_b", b_vec, mk(1'b0, 1'b0, '0, 2'b01, 2'b00, 1'b1));
        idle();
        chk("flush_end_b", b_vec, '0);

        // First latched jump wins over a later one
        step(1'b1, 64'h300, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h400, 1'b0, 1'b1, 1'b0);
        idle();
        chk("first_wins_a", a_vec, mk(1'b0, 1'b1, 64'h300, 2'b01, 2'b01, 1'b1));
        idle(); idle(); idle();

        // Release with nothing pending: live jump beats load-use
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h500, 1'b0, 1'b0, 1'b1);
        chk("release_live_jump_a", a_vec, mk(1'b0, 1'b1, 64'h500, 2'b01, 2'b01, 1'b1));
        idle(); idle(); idle();

        // Async reset mid-stall discards the pending jump
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h600, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        #1; rst = 1'b1; #1;
        chk("rst_mid_a", a_vec, '0);
        chk("rst_mid_b", b_vec, '0);
        @(posedge clk); #1;
        stall_div = 1'b0; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("no_jump_after_rst_a", {70'b0, a_jf}, 71'b0);
            chk("no_jump_after_rst_b", {70'b0, b_jf}, 71'b0);
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
